// File: rtl/uart_trx.sv
`default_nettype none
// ============================================================================
// Module   : uart_trx
// Purpose  : UART transceiver with a 16x oversampling receiver, TX and RX
//            FIFOs, and frame format chosen at runtime (5-8 data bits,
//            none/odd/even parity, 1 or 2 stop bits).
// Ports    : clk_i / arst_ni          - clock, asynchronous active-low reset
//            cfg_*                    - divider and frame format (latched
//                                       per frame)
//            tx_data/valid/ready      - TX byte stream into the TX FIFO
//            rx_data/valid/ready      - RX byte stream out of the RX FIFO
//            tx_o / rx_i              - serial line out / in (rx_i async)
//            tx/rx_active_o           - frame in progress
//            tx/rx_count_o            - FIFO occupancy
//            rx_*_err_o, rx_overflow_o, clear_err_i - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module uart_trx #(
    parameter  int FIFO_DEPTH = 8,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic [15:0]   cfg_clk_div_i,
    input  logic [1:0]    cfg_data_width_i,
    input  logic [1:0]    cfg_parity_i,
    input  logic          cfg_stop_width_i,
    input  logic [7:0]    tx_data_i,
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    output logic [7:0]    rx_data_o,
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    output logic          tx_o,
    input  logic          rx_i,
    output logic          tx_active_o,
    output logic          rx_active_o,
    output logic [CW-1:0] tx_count_o,
    output logic [CW-1:0] rx_count_o,
    output logic          rx_parity_err_o,
    output logic          rx_frame_err_o,
    output logic          rx_overflow_o,
    input  logic          clear_err_i
);

    localparam int            c_aw        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] c_full      = CW'(FIFO_DEPTH);
    localparam logic [2:0]    c_st_idle   = 3'd0;
    localparam logic [2:0]    c_st_start  = 3'd1;
    localparam logic [2:0]    c_st_data   = 3'd2;
    localparam logic [2:0]    c_st_parity = 3'd3;
    localparam logic [2:0]    c_st_stop   = 3'd4;

    // ------------------------------------------------------------------
    // Oversample tick: one-cycle pulse every max(div,1) clocks.
    // ------------------------------------------------------------------
    logic [15:0] r_tick_cnt;
    logic        r_tick;
    logic [15:0] w_div_m1;

    assign w_div_m1 = (cfg_clk_div_i == 16'd0) ? 16'd0 : cfg_clk_div_i - 16'd1;

    // ">=" keeps the counter bounded if the divider shrinks mid-count.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_tick_cnt <= 16'd0;
            r_tick     <= 1'b0;
        end else if (r_tick_cnt >= w_div_m1) begin
            r_tick_cnt <= 16'd0;
            r_tick     <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
            r_tick     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_tx_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_tx_wr, r_tx_rd;
    logic [CW-1:0]   r_tx_count, w_tx_count_nxt;
    logic            r_tx_ready;
    logic            w_tx_push, w_tx_pop;
    logic [2:0]      r_tx_state;

    assign w_tx_push      = tx_valid_i && r_tx_ready;
    assign w_tx_pop       = r_tick && (r_tx_state == c_st_idle) && (r_tx_count != '0);
    assign w_tx_count_nxt = r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);

    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_data_i;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_count <= '0;
            r_tx_ready <= 1'b1;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + c_aw'(1);
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_aw'(1);
            r_tx_count <= w_tx_count_nxt;
            r_tx_ready <= (w_tx_count_nxt != c_full);
        end
    end

    // ------------------------------------------------------------------
    // TX FSM. r_tx_tick counts ticks within the current bit; a bit ends on
    // the tick seen while it reads 15.
    // ------------------------------------------------------------------
    logic [3:0] r_tx_tick;
    logic [2:0] r_tx_bit, r_tx_last;
    logic [7:0] r_tx_shift;
    logic       r_tx_line, r_tx_active, r_tx_par_en, r_tx_par_bit;
    logic       r_tx_stop2, r_tx_stop_cnt;
    logic [7:0] w_tx_masked;
    logic       w_tx_bit_end;

    assign w_tx_masked  = r_tx_mem[r_tx_rd] & (8'hFF >> (2'd3 - cfg_data_width_i));
    assign w_tx_bit_end = r_tick && (r_tx_tick == 4'hF);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_tx_state    <= c_st_idle;
            r_tx_line     <= 1'b1;
            r_tx_active   <= 1'b0;
            r_tx_tick     <= 4'd0;
            r_tx_bit      <= 3'd0;
            r_tx_last     <= 3'd7;
            r_tx_shift    <= 8'd0;
            r_tx_par_en   <= 1'b0;
            r_tx_par_bit  <= 1'b0;
            r_tx_stop2    <= 1'b0;
            r_tx_stop_cnt <= 1'b0;
        end else if (r_tx_state == c_st_idle) begin
            if (w_tx_pop) begin
                r_tx_state    <= c_st_start;
                r_tx_line     <= 1'b0;
                r_tx_active   <= 1'b1;
                r_tx_tick     <= 4'd0;
                r_tx_bit      <= 3'd0;
                r_tx_shift    <= w_tx_masked;
                r_tx_last     <= {1'b0, cfg_data_width_i} + 3'd4;
                r_tx_par_en   <= (cfg_parity_i == 2'd1) || (cfg_parity_i == 2'd2);
                // Even: parity = XOR of data; odd: its complement.
                r_tx_par_bit  <= (^w_tx_masked) ^ (cfg_parity_i == 2'd1);
                r_tx_stop2    <= cfg_stop_width_i;
                r_tx_stop_cnt <= 1'b0;
            end
        end else if (r_tick) begin
            r_tx_tick <= r_tx_tick + 4'd1;
            if (w_tx_bit_end) begin
                case (r_tx_state)
                    c_st_start: begin
                        r_tx_state <= c_st_data;
                        r_tx_line  <= r_tx_shift[0];
                    end
                    c_st_data: begin
                        if (r_tx_bit == r_tx_last) begin
                            r_tx_state    <= r_tx_par_en ? c_st_parity : c_st_stop;
                            r_tx_line     <= r_tx_par_en ? r_tx_par_bit : 1'b1;
                            r_tx_stop_cnt <= 1'b0;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_line  <= r_tx_shift[1];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end
                    c_st_parity: begin
                        r_tx_state    <= c_st_stop;
                        r_tx_line     <= 1'b1;
                        r_tx_stop_cnt <= 1'b0;
                    end
                    default: begin
                        if (r_tx_stop2 && !r_tx_stop_cnt) begin
                            r_tx_stop_cnt <= 1'b1;
                        end else begin
                            r_tx_state  <= c_st_idle;
                            r_tx_line   <= 1'b1;
                            r_tx_active <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // RX input synchronizer and falling-edge detect.
    // ------------------------------------------------------------------
    logic [1:0] r_rx_sync;
    logic       r_rx_prev;
    logic       w_rx_in;

    assign w_rx_in = r_rx_sync[1];

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rx_sync <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx_i};
            r_rx_prev <= w_rx_in;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM. Start is confirmed at the 8th tick after the edge, which
    // places every later 16-tick sample in the middle of its bit.
    // ------------------------------------------------------------------
    logic [2:0] r_rx_state;
    logic [3:0] r_rx_tick;
    logic [2:0] r_rx_bit, r_rx_last;
    logic [7:0] r_rx_shift;
    logic       r_rx_par, r_rx_par_en, r_rx_par_odd, r_rx_active;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rx_state   <= c_st_idle;
            r_rx_active  <= 1'b0;
            r_rx_tick    <= 4'd0;
            r_rx_bit     <= 3'd0;
            r_rx_last    <= 3'd7;
            r_rx_shift   <= 8'd0;
            r_rx_par     <= 1'b0;
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
        end else begin
            case (r_rx_state)
                c_st_idle: begin
                    if (r_rx_prev && !w_rx_in) begin
                        r_rx_state   <= c_st_start;
                        r_rx_active  <= 1'b1;
                        r_rx_tick    <= 4'd0;
                        r_rx_bit     <= 3'd0;
                        r_rx_shift   <= 8'd0;
                        r_rx_last    <= {1'b0, cfg_data_width_i} + 3'd4;
                        r_rx_par_en  <= (cfg_parity_i == 2'd1) || (cfg_parity_i == 2'd2);
                        r_rx_par_odd <= (cfg_parity_i == 2'd1);
                    end
                end
                c_st_start: begin
                    if (r_tick) begin
                        if (r_rx_tick == 4'd7) begin
                            r_rx_tick <= 4'd0;
                            if (w_rx_in) begin
                                r_rx_state  <= c_st_idle;
                                r_rx_active <= 1'b0;
                            end else begin
                                r_rx_state <= c_st_data;
                            end
                        end else begin
                            r_rx_tick <= r_rx_tick + 4'd1;
                        end
                    end
                end
                default: begin
                    if (r_tick) begin
                        r_rx_tick <= r_rx_tick + 4'd1;
                        if (r_rx_tick == 4'hF) begin
                            case (r_rx_state)
                                c_st_data: begin
                                    r_rx_shift[r_rx_bit] <= w_rx_in;
                                    if (r_rx_bit == r_rx_last) begin
                                        r_rx_state <= r_rx_par_en ? c_st_parity : c_st_stop;
                                    end else begin
                                        r_rx_bit <= r_rx_bit + 3'd1;
                                    end
                                end
                                c_st_parity: begin
                                    r_rx_par   <= w_rx_in;
                                    r_rx_state <= c_st_stop;
                                end
                                default: begin
                                    r_rx_state  <= c_st_idle;
                                    r_rx_active <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX result, FIFO and sticky flags.
    // ------------------------------------------------------------------
    logic [7:0]      r_rx_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_rx_wr, r_rx_rd, w_rx_rd_nxt;
    logic [CW-1:0]   r_rx_count, w_rx_count_nxt;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid, r_par_err, r_frm_err, r_ovf;
    logic            w_rx_done, w_rx_par_ok, w_rx_good, w_rx_push, w_rx_pop;
    logic            w_rx_full_drop, w_rx_head_new;

    assign w_rx_done      = r_tick && (r_rx_state == c_st_stop) && (r_rx_tick == 4'hF);
    assign w_rx_par_ok    = !r_rx_par_en || (((^r_rx_shift) ^ r_rx_par) == r_rx_par_odd);
    assign w_rx_good      = w_rx_done && w_rx_par_ok && w_rx_in;
    assign w_rx_pop       = r_rx_valid && rx_ready_i;
    // A pop in the same cycle frees the slot, so full only drops without one.
    assign w_rx_full_drop = (r_rx_count == c_full) && !w_rx_pop;
    assign w_rx_push      = w_rx_good && !w_rx_full_drop;
    assign w_rx_rd_nxt    = r_rx_rd + c_aw'(w_rx_pop);
    assign w_rx_count_nxt = r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);
    // The pushed byte becomes the head when nothing else remains after the pop.
    assign w_rx_head_new  = w_rx_push && (r_rx_count == CW'(w_rx_pop));

    always_ff @(posedge clk_i) begin
        if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx_shift;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_count <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'd0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + c_aw'(1);
            r_rx_rd    <= w_rx_rd_nxt;
            r_rx_count <= w_rx_count_nxt;
            r_rx_valid <= (w_rx_count_nxt != '0);
            if (w_rx_count_nxt == '0) r_rx_data <= 8'd0;
            else if (w_rx_head_new)   r_rx_data <= r_rx_shift;
            else                      r_rx_data <= r_rx_mem[w_rx_rd_nxt];
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_rx_done && !w_rx_par_ok)          r_par_err <= 1'b1;
            else if (clear_err_i)                   r_par_err <= 1'b0;
            if (w_rx_done && !w_rx_in)              r_frm_err <= 1'b1;
            else if (clear_err_i)                   r_frm_err <= 1'b0;
            if (w_rx_good && w_rx_full_drop)        r_ovf     <= 1'b1;
            else if (clear_err_i)                   r_ovf     <= 1'b0;
        end
    end

    assign tx_ready_o      = r_tx_ready;
    assign tx_o            = r_tx_line;
    assign tx_active_o     = r_tx_active;
    assign tx_count_o      = r_tx_count;
    assign rx_data_o       = r_rx_data;
    assign rx_valid_o      = r_rx_valid;
    assign rx_active_o     = r_rx_active;
    assign rx_count_o      = r_rx_count;
    assign rx_parity_err_o = r_par_err;
    assign rx_frame_err_o  = r_frm_err;
    assign rx_overflow_o   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_trx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_trx
// Purpose  : Self-checking bench for uart_trx. A frame-level model yields
//            the expected serial bits, frame lengths and received bytes;
//            a TX line monitor and an RX stream scoreboard compare them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_trx;

    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int D     = 4;
    localparam int BIT   = 16 * D;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        int         par;    // 0 none, 1 odd, 2 even
        int         stop2;
    } frame_t;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [15:0]   cfg_clk_div = 16'(D);
    logic [1:0]    cfg_data_width = 2'd3;
    logic [1:0]    cfg_parity = 2'd0;
    logic          cfg_stop_width = 1'b0;
    logic [7:0]    tx_data = 8'd0;
    logic          tx_valid = 1'b0;
    logic          tx_ready_o;
    logic [7:0]    rx_data_o;
    logic          rx_valid_o;
    logic          rx_ready = 1'b1;
    logic          tx_o;
    logic          rx_in;
    logic          rx_line = 1'b1;
    logic          loopback = 1'b1;
    logic          tx_active_o, rx_active_o;
    logic [CW-1:0] tx_count_o, rx_count_o;
    logic          rx_parity_err_o, rx_frame_err_o, rx_overflow_o;
    logic          clear_err = 1'b0;

    int     n_checks = 0;
    int     n_fail   = 0;
    frame_t exp_tx[$];
    logic [7:0] exp_rx[$];
    logic   mon_prev = 1'b1;

    assign rx_in = loopback ? tx_o : rx_line;

    uart_trx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .arst_ni(arst_n),
        .cfg_clk_div_i(cfg_clk_div), .cfg_data_width_i(cfg_data_width),
        .cfg_parity_i(cfg_parity), .cfg_stop_width_i(cfg_stop_width),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
        .tx_o(tx_o), .rx_i(rx_in),
        .tx_active_o(tx_active_o), .rx_active_o(rx_active_o),
        .tx_count_o(tx_count_o), .rx_count_o(rx_count_o),
        .rx_parity_err_o(rx_parity_err_o), .rx_frame_err_o(rx_frame_err_o),
        .rx_overflow_o(rx_overflow_o), .clear_err_i(clear_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model ----------------
    function automatic frame_t mk(input logic [7:0] d, input int n, input int p, input int s);
        frame_t f;
        f.data = d; f.nbits = n; f.par = p; f.stop2 = s;
        return f;
    endfunction

    function automatic int frame_len(input frame_t f);
        return 1 + f.nbits + ((f.par != 0) ? 1 : 0) + ((f.stop2 != 0) ? 2 : 1);
    endfunction

    function automatic int frame_bit(input frame_t f, input int i);
        int ones;
        if (i == 0) return 0;
        if (i <= f.nbits) return int'(f.data[i-1]);
        if (f.par != 0 && i == f.nbits + 1) begin
            ones = 0;
            for (int k = 0; k < f.nbits; k++) ones += int'(f.data[k]);
            return (f.par == 1) ? ((ones % 2 == 0) ? 1 : 0) : (ones % 2);
        end
        return 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic set_cfg(input frame_t f);
        cfg_data_width = 2'(f.nbits - 5);
        cfg_parity     = 2'(f.par);
        cfg_stop_width = (f.stop2 != 0);
    endtask

    // Caller is just after a posedge; returns just after the accepting posedge
    // with tx_valid still high so consecutive calls are back-to-back.
    task automatic write_tx(input logic [7:0] b);
        int w;
        tx_data = b; tx_valid = 1'b1; w = 0;
        forever begin
            @(negedge clk);
            if (tx_ready_o) break;
            w++;
            if (w > 5000) begin check("tx_write_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic drive_frame(input frame_t f, input bit bad_par, input bit bad_stop);
        int b;
        for (int i = 0; i < frame_len(f); i++) begin
            b = frame_bit(f, i);
            if (bad_par && f.par != 0 && i == f.nbits + 1) b = 1;
            if (bad_stop && i == 1 + f.nbits + ((f.par != 0) ? 1 : 0)) b = 0;
            rx_line = b[0];
            repeat (BIT) @(posedge clk);
        end
        rx_line = 1'b1;
        repeat (16) @(posedge clk);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        do begin
            @(negedge clk); w++;
        end while ((tx_count_o != 0 || tx_active_o || rx_active_o || rx_valid_o) && w < 20000);
        check("wait_idle_timeout", (w < 20000) ? 1 : 0, 1);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- TX line monitor ----------------
    initial begin : tx_mon
        frame_t f;
        int c, len;
        bit aborted;
        forever begin
            @(negedge clk);
            if (arst_n && mon_prev && !tx_o) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected_frame", 1, 0);
                end else begin
                    f = exp_tx.pop_front();
                    len = BIT * frame_len(f);
                    c = 0; aborted = 0;
                    while (1) begin
                        if (!arst_n) begin aborted = 1; break; end
                        if (!tx_active_o || c > len + 100) break;
                        if (c % BIT == BIT / 2) check("tx_bit", int'(tx_o), frame_bit(f, c / BIT));
                        @(negedge clk); c++;
                    end
                    if (!aborted) check("tx_frame_len", c, len);
                end
            end
            mon_prev = tx_o;
        end
    end

    // ---------------- RX stream scoreboard ----------------
    always @(negedge clk) begin
        if (arst_n && rx_valid_o && rx_ready) begin
            if (exp_rx.size() == 0) check("rx_unexpected_byte", int'(rx_data_o), -1);
            else                    check("rx_data", int'(rx_data_o), int'(exp_rx.pop_front()));
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        frame_t f;
        int n, v;

        // Model pinned against hand-computed literals.
        f = mk(8'h00, 8, 0, 0);
        check("model_8n1_len", BIT * frame_len(f), 640);
        f = mk(8'h53, 7, 2, 1);
        v = 0;
        for (int i = 0; i < frame_len(f); i++) v += frame_bit(f, i) << i;
        check("model_7e2_bits", v, 1702);
        f = mk(8'h01, 8, 1, 0);
        check("model_8o1_parity", frame_bit(f, 9), 0);

        // Reset values.
        #12;
        check("rst_tx_o", int'(tx_o), 1);
        check("rst_tx_ready", int'(tx_ready_o), 1);
        check("rst_rx_valid", int'(rx_valid_o), 0);
        check("rst_rx_data", int'(rx_data_o), 0);
        check("rst_counts", int'(tx_count_o) + int'(rx_count_o), 0);
        check("rst_active", int'(tx_active_o) + int'(rx_active_o), 0);
        check("rst_flags", int'(rx_parity_err_o) + int'(rx_frame_err_o) + int'(rx_overflow_o), 0);
        @(posedge clk); #1 arst_n = 1'b1;
        repeat (4) @(posedge clk); #1;

        // Loopback 8N1: 0x00, 0xA5, 0xFF.
        loopback = 1'b1; rx_ready = 1'b1;
        set_cfg(mk(8'h00, 8, 0, 0));
        exp_tx.push_back(mk(8'h00, 8, 0, 0));
        exp_tx.push_back(mk(8'hA5, 8, 0, 0));
        exp_tx.push_back(mk(8'hFF, 8, 0, 0));
        exp_rx.push_back(8'h00); exp_rx.push_back(8'hA5); exp_rx.push_back(8'hFF);
        write_tx(8'h00); tx_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (tx_o && n < 50);
        check("tx_latency_within_bound", (n <= D + 2) ? 1 : 0, 1);
        @(posedge clk); #1;
        write_tx(8'hA5); write_tx(8'hFF); tx_valid = 1'b0;
        wait_idle();
        check("lb_rx_all_received", exp_rx.size(), 0);
        check("lb_flags", int'(rx_parity_err_o) + int'(rx_frame_err_o) + int'(rx_overflow_o), 0);

        // Loopback 7E2 0x53.
        f = mk(8'h53, 7, 2, 1);
        set_cfg(f); exp_tx.push_back(f); exp_rx.push_back(8'h53);
        @(posedge clk); #1; write_tx(8'h53); tx_valid = 1'b0;
        wait_idle();
        check("7e2_rx_received", exp_rx.size(), 0);

        // Parity error: 8O1 0x01 with parity forced to 1.
        loopback = 1'b0;
        f = mk(8'h01, 8, 1, 0);
        set_cfg(f); drive_frame(f, 1'b1, 1'b0);
        @(negedge clk);
        check("par_err_set", int'(rx_parity_err_o), 1);
        check("par_no_push", int'(rx_count_o), 0);
        check("par_no_frame_err", int'(rx_frame_err_o), 0);
        pulse_clear();
        check("par_err_cleared", int'(rx_parity_err_o), 0);

        // Framing error: 8N1 stop bit driven low.
        f = mk(8'h3C, 8, 0, 0);
        set_cfg(f); drive_frame(f, 1'b0, 1'b1);
        @(negedge clk);
        check("frm_err_set", int'(rx_frame_err_o), 1);
        check("frm_no_push", int'(rx_count_o), 0);
        pulse_clear();
        check("frm_err_cleared", int'(rx_frame_err_o), 0);

        // False start: 4-tick low glitch.
        @(posedge clk); rx_line = 1'b0;
        repeat (4 * D) @(posedge clk);
        @(negedge clk);
        check("glitch_active_rises", int'(rx_active_o), 1);
        rx_line = 1'b1;
        repeat (BIT) @(negedge clk);
        check("glitch_active_falls", int'(rx_active_o), 0);
        check("glitch_no_push", int'(rx_count_o), 0);
        check("glitch_no_flags", int'(rx_parity_err_o) + int'(rx_frame_err_o), 0);

        // Overflow: 9 bytes with rx_ready low.
        rx_ready = 1'b0;
        set_cfg(mk(8'h00, 8, 0, 0));
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_rx.push_back(8'(8'h10 + i));
            drive_frame(mk(8'(8'h10 + i), 8, 0, 0), 1'b0, 1'b0);
            if (i == 7) begin
                @(negedge clk);
                check("ovf_count_8", int'(rx_count_o), 8);
                check("ovf_not_yet", int'(rx_overflow_o), 0);
                check("ovf_head", int'(rx_data_o), 8'h10);
            end
        end
        @(negedge clk);
        check("ovf_count_held", int'(rx_count_o), 8);
        check("ovf_flag", int'(rx_overflow_o), 1);
        @(posedge clk); #1 rx_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("ovf_drained", exp_rx.size(), 0);
        check("ovf_count_0", int'(rx_count_o), 0);
        pulse_clear();
        check("ovf_cleared", int'(rx_overflow_o), 0);

        // TX backpressure: 9 back-to-back writes, looped back.
        loopback = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_tx.push_back(mk(8'(8'hC0 + i), 8, 0, 0));
            exp_rx.push_back(8'(8'hC0 + i));
        end
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) write_tx(8'(8'hC0 + i));
        tx_valid = 1'b0;
        @(negedge clk);
        check("bp_tx_count_full", int'(tx_count_o), 8);
        check("bp_tx_ready_low", int'(tx_ready_o), 0);
        wait_idle();
        check("bp_all_sent", exp_tx.size(), 0);
        check("bp_all_received", exp_rx.size(), 0);

        // Asynchronous reset mid-frame.
        exp_tx.push_back(mk(8'h77, 8, 0, 0));
        @(posedge clk); #1; write_tx(8'h77); tx_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_active_o && n < 50);
        check("rst_frame_started", int'(tx_active_o), 1);
        repeat (100) @(posedge clk);
        #3 arst_n = 1'b0;
        #1;
        check("arst_tx_o_high", int'(tx_o), 1);
        check("arst_counts", int'(tx_count_o) + int'(rx_count_o), 0);
        check("arst_active", int'(tx_active_o) + int'(rx_active_o), 0);
        @(posedge clk); #1 arst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("post_rst_rx_idle", int'(rx_valid_o) + int'(rx_active_o), 0);
        check("post_rst_tx_idle", int'(tx_o), 1);
        check("final_tx_queue", exp_tx.size(), 0);
        check("final_rx_queue", exp_rx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_trx.md
# uart_trx

Synthesizable, parametrised UART transceiver that turns the team's behavioural UART bench model into RTL for SoC integration. It serialises bytes from a TX FIFO onto `tx_o`, deserialises `rx_i` through a 16x oversampling receiver into an RX FIFO, and handles frame format at runtime: 5–8 data bits, none/odd/even parity, 1 or 2 stop bits. Both sides use valid/ready streams. Sticky error flags report parity, framing and overflow errors.

## Interface
- `FIFO_DEPTH`, 8: entries per TX and RX FIFO; power of two, ≥2.
- `CW`, localparam `$clog2(FIFO_DEPTH)+1`: occupancy count width.

Ports:
- `clk_i` in 1: sole clock.
- `arst_ni` in 1: asynchronous, active-low reset.
- `cfg_clk_div_i` in 16: clocks per oversample tick; D = max(value,1).
- `cfg_data_width_i` in 2: data bits = value+5.
- `cfg_parity_i` in 2: 0 none, 1 odd, 2 even, 3 none.
- `cfg_stop_width_i` in 1: 0 one stop bit, 1 two stop bits.
- `tx_data_i` in 8, `tx_valid_i` in 1, `tx_ready_o` out 1: TX byte stream.
- `rx_data_o` out 8, `rx_valid_o` out 1, `rx_ready_i` in 1: RX byte stream; unused MSBs read 0.
- `tx_o` out 1: serial out; idle 1.
- `rx_i` in 1: serial in; asynchronous to `clk_i`.
- `tx_active_o`, `rx_active_o` out 1: frame in progress.
- `tx_count_o`, `rx_count_o` out CW: FIFO occupancy.
- `rx_parity_err_o`, `rx_frame_err_o`, `rx_overflow_o` out 1: sticky error flags.
- `clear_err_i` in 1: clears all sticky flags.

## Operation
- Tick generator: a free-running counter asserts one-cycle `tick` every D clocks. One bit time is 16 ticks.
- Config capture: TX and RX each latch cfg_* at frame start. Changes mid-frame affect only the next frame.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE.
  - In IDLE with the FIFO non-empty, on `tick`: pop the byte and enter START.
  - Each state lasts 16 ticks per bit. Data is sent LSB first.
  - Odd parity makes the total count of ones (data+parity) odd; even parity makes it even.
  - STOP lasts 1 or 2 bits.
- RX input path: 2-FF synchronizer on `rx_i`, reset value 1.
- RX FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - A falling edge in IDLE enters START. At 8 ticks the line is resampled; if it is 1 this is a false start and the FSM returns to IDLE.
  - Later bits are sampled every 16 ticks (mid-bit).
  - STOP checks only the first stop bit. After that mid-bit sample the FSM returns to IDLE, ready for the next start edge.
- RX result:
  - Parity mismatch: drop byte, set `rx_parity_err_o`.
  - Stop bit 0: drop byte, set `rx_frame_err_o`.
  - Good byte with RX FIFO full: drop byte, set `rx_overflow_o`.
  - Otherwise push the byte.
- FIFOs: `tx_ready_o` = !TX full. `rx_valid_o` = !RX empty. `rx_data_o` shows the head entry. No bypass path.
- A simultaneous push and pop leaves the count unchanged; this is legal even when full (RX) or empty-after-pop (TX).
- `clear_err_i`: if an error event occurs in the same cycle, set wins.

## Timing
- Reset values:
  - `tx_o`=1, `tx_ready_o`=1, `rx_valid_o`=0, `rx_data_o`=0.
  - Counts 0, active flags 0, error flags 0.
  - FIFOs emptied, FSMs in IDLE, tick counter 0.
- Reset mid-frame: `tx_o` returns to 1 asynchronously and the partial RX frame is discarded.
- All outputs are registered.
- TX latency: write into an empty idle TX → `tx_o` falls within D+2 cycles.
- `tx_active_o` rises with the start bit and falls after the last stop bit's 16th tick.
- RX latency: `rx_valid_o` rises ≤ D+3 cycles after the first stop bit's mid-bit sample; the synchronizer adds 2 cycles.
- Flags assert in the same cycle the byte would have been pushed.
- Frame length: 16·D·(1+N+P+S) clocks, where N = data bits, P ∈ {0,1}, S ∈ {1,2}.

## Test plan
- Loopback (`tx_o`→`rx_i`), D=4, 8N1: send 0x00, 0xA5, 0xFF → RX returns 0x00, 0xA5, 0xFF in order; no flags; each frame 640 clocks.
- 7E2 send 0x53 → `tx_o` shows 0, 1100101, 0, 1, 1; RX reads 0x53.
- Bench drives 8O1 0x01 with the parity bit forced to 1 → nothing pushed, `rx_parity_err_o`=1; `clear_err_i` pulse → 0.
- RX framing and false start:
  - Stop bit driven 0 → byte dropped, `rx_frame_err_o`=1.
  - A 4-tick low glitch → no frame, `rx_active_o` returns to 0.
- RX FIFO_DEPTH=8 with `rx_ready_i`=0: receive 9 bytes → count 8, `rx_overflow_o`=1, first 8 bytes intact.
- TX backpressure and reset:
  - Write 9 bytes back-to-back → `tx_ready_o`=0 once full (8 after the first pop); all 9 are sent.
  - `arst_ni` low mid-frame → `tx_o`=1 immediately, counts 0.
